bcd_countdown_timer: RTL and testbench

- Multi-digit BCD down-counter for the game timer. It is the decrementing counterpart of the score digit chain: it borrows across digits where the score chain carries.
- Loads a start time, counts down one unit per external tick while running, and flags timeout at 00.
- Sits between the tick generator (1 Hz pulse) and the 7-segment display/game controller.

---
 rtl/bcd_timer_pkg.sv | 18 +
 rtl/bcd_down_digit.sv | 41 ++++
 rtl/bcd_countdown_timer.sv | 142 ++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } timer_state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown chain; borrows from the next digit up when
// it and every digit below it are zero.
import bcd_timer_pkg::*;

module bcd_down_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       dec_en,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       is_zero,
  output logic       borrow_out
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  assign digit      = digit_q;
  assign is_zero    = (digit_q == BCD_ZERO);
  assign borrow_out = borrow_in & is_zero;

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_digit;
    end else if (dec_en && borrow_in) begin
      digit_d = is_zero ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with IDLE/RUN/PAUSE/DONE control.
// Optional BCD_COUNTDOWN_AUTO_RELOAD_EN restarts from the loaded value on timeout.
import bcd_timer_pkg::*;

module bcd_countdown_timer #(
  parameter int NUM_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    tick,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    done,
  output logic                    timeout
);

  timer_state_e state_q, state_d;
  logic [4*NUM_DIGITS-1:0] reload_q, reload_d;
  logic running_q, running_d;
  logic done_q, done_d;
  logic timeout_q, timeout_d;

  logic [4*NUM_DIGITS-1:0] clamped_value;
  logic [4*NUM_DIGITS-1:0] digit_vec;
  logic [4*NUM_DIGITS-1:0] dig_load_val;
  logic [NUM_DIGITS-1:0]   is_zero;
  logic [NUM_DIGITS:0]     borrow;
  logic dig_load;
  logic dec_en;
  logic all_zero;
  logic upper_zero;
  logic hits_zero;

  assign borrow[0] = 1'b1;
  assign all_zero  = borrow[NUM_DIGITS];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    assign clamped_value[4*i +: 4] = clamp_bcd(load_value[4*i +: 4]);

    bcd_down_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (dig_load),
      .load_digit (dig_load_val[4*i +: 4]),
      .dec_en     (dec_en),
      .borrow_in  (borrow[i]),
      .digit      (digit_vec[4*i +: 4]),
      .is_zero    (is_zero[i]),
      .borrow_out (borrow[i+1])
    );
  end

  // The next tick lands on zero exactly when the current value is 1.
  always_comb begin
    upper_zero = 1'b1;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      upper_zero = upper_zero & is_zero[i];
    end
    hits_zero = !is_zero[0] && (digit_vec[3:0] == 4'd1) && upper_zero;
  end

  always_comb begin
    state_d      = state_q;
    reload_d     = reload_q;
    timeout_d    = 1'b0;
    dec_en       = 1'b0;
    dig_load     = 1'b0;
    dig_load_val = clamped_value;

    if (load) begin
      dig_load = 1'b1;
      reload_d = clamped_value;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !pause && !all_zero) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSE;
          end
          if (tick) begin
            dec_en = 1'b1;
            if (hits_zero) begin
              timeout_d = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
              if (reload_q != '0) begin
                dig_load     = 1'b1;
                dig_load_val = reload_q;
              end else begin
                state_d = DONE;
              end
`else
              state_d = DONE;
`endif
            end
          end
        end
        PAUSE: begin
          if (start && !pause) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = DONE;
        end
      endcase
    end

    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      reload_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign digits  = digit_vec;
  assign running = running_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed scoreboard bench for bcd_countdown_timer with NUM_DIGITS=2.
module tb_bcd_countdown_timer;

  typedef struct {
    string      tag;
    logic [7:0] digits;
    logic       running;
    logic       done;
    logic       timeout;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] digits;
  logic       running;
  logic       done;
  logic       timeout;

  exp_t sb_q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  bcd_countdown_timer #(.NUM_DIGITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .tick       (tick),
    .digits     (digits),
    .running    (running),
    .done       (done),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

  task automatic pushExp(input string tag, input logic [7:0] ed, input logic er,
                         input logic edn, input logic eto);
    exp_t e;
    e.tag = tag; e.digits = ed; e.running = er; e.done = edn; e.timeout = eto;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    total_cnt++;
    if (sb_q.size() == 0) begin
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = sb_q.pop_front();
    assert (digits === e.digits && running === e.running && done === e.done
            && timeout === e.timeout) pass_cnt++;
    else $error("[TB] FAIL %s observed digits=%h run=%b done=%b to=%b expected digits=%h run=%b done=%b to=%b",
                e.tag, digits, running, done, timeout, e.digits, e.running, e.done, e.timeout);
  endtask

  task automatic applyStimulus(input string tag, input logic ld, input logic [7:0] lv,
                               input logic st, input logic ps, input logic tk,
                               input logic [7:0] ed, input logic er, input logic edn,
                               input logic eto);
    @(negedge clk);
    load = ld; load_value = lv; start = st; pause = ps; tick = tk;
    pushExp(tag, ed, er, edn, eto);
    @(posedge clk);
    #1;
    checkOutput();
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b1;
    #2;
    pushExp("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    // 12 down to 0, then ticks in DONE
    applyStimulus("load12", 1, 8'h12, 0, 0, 0, 8'h12, 0, 0, 0);
    applyStimulus("start12", 0, 8'h00, 1, 0, 0, 8'h12, 1, 0, 0);
    for (int v = 11; v >= 1; v--) begin
      applyStimulus("count12", 0, 8'h00, 0, 0, 1, to_bcd(v), 1, 0, 0);
    end
    applyStimulus("hit_zero", 0, 8'h00, 0, 0, 1, AUTO ? 8'h12 : 8'h00, AUTO, !AUTO, 1);
    applyStimulus("after_zero", 0, 8'h00, 0, 0, 1, AUTO ? 8'h11 : 8'h00, AUTO, !AUTO, 0);
    applyStimulus("done_start", 0, 8'h00, 1, 0, 1, AUTO ? 8'h10 : 8'h00, AUTO, !AUTO, 0);

    // borrow from tens
    applyStimulus("load10", 1, 8'h10, 0, 0, 0, 8'h10, 0, 0, 0);
    applyStimulus("start10", 0, 8'h00, 1, 0, 0, 8'h10, 1, 0, 0);
    applyStimulus("borrow09", 0, 8'h00, 0, 0, 1, 8'h09, 1, 0, 0);
    applyStimulus("dec08", 0, 8'h00, 0, 0, 1, 8'h08, 1, 0, 0);

    // pause and resume
    applyStimulus("load05", 1, 8'h05, 0, 0, 0, 8'h05, 0, 0, 0);
    applyStimulus("start05", 0, 8'h00, 1, 0, 0, 8'h05, 1, 0, 0);
    applyStimulus("dec04", 0, 8'h00, 0, 0, 1, 8'h04, 1, 0, 0);
    applyStimulus("dec03", 0, 8'h00, 0, 0, 1, 8'h03, 1, 0, 0);
    applyStimulus("pause03", 0, 8'h00, 0, 1, 0, 8'h03, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("paused_tick", 0, 8'h00, 0, 0, 1, 8'h03, 0, 0, 0);
    end
    applyStimulus("resume", 0, 8'h00, 1, 0, 0, 8'h03, 1, 0, 0);
    applyStimulus("dec02", 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0);

    // simultaneous controls, clamped load
    applyStimulus("load08", 1, 8'h08, 0, 0, 0, 8'h08, 0, 0, 0);
    applyStimulus("start08", 0, 8'h00, 1, 0, 0, 8'h08, 1, 0, 0);
    applyStimulus("dec07", 0, 8'h00, 0, 0, 1, 8'h07, 1, 0, 0);
    applyStimulus("tick_start_pause", 0, 8'h00, 1, 1, 1, 8'h06, 0, 0, 0);
    applyStimulus("load_clamp_tick", 1, 8'hA3, 0, 0, 1, 8'h93, 0, 0, 0);
    applyStimulus("idle_tick", 0, 8'h00, 0, 0, 1, 8'h93, 0, 0, 0);
    applyStimulus("load_clamp_both", 1, 8'hFC, 0, 0, 0, 8'h99, 0, 0, 0);

    // zero load cannot start
    applyStimulus("load00", 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0);
    applyStimulus("start00", 0, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0);
    applyStimulus("start00_hold", 0, 8'h00, 1, 0, 1, 8'h00, 0, 0, 0);

    // async reset mid-run
    applyStimulus("load45", 1, 8'h45, 0, 0, 0, 8'h45, 0, 0, 0);
    applyStimulus("start45", 0, 8'h00, 1, 0, 0, 8'h45, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    pushExp("async_rst", 8'h00, 0, 0, 0);
    checkOutput();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("post_rst_tick", 0, 8'h00, 1, 0, 1, 8'h00, 0, 0, 0);

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    applyStimulus("ar_load02", 1, 8'h02, 0, 0, 0, 8'h02, 0, 0, 0);
    applyStimulus("ar_start", 0, 8'h00, 1, 0, 0, 8'h02, 1, 0, 0);
    applyStimulus("ar_dec01", 0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0);
    applyStimulus("ar_reload", 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 1);
    applyStimulus("ar_dec01b", 0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
